addsub_16bit_serial: RTL
========================

ADDSUB_16BIT_SERIAL -- requirements
Module: addsub_16bit_serial

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only when idle or in the DONE cycle.
REQ-005 A  input  16  minuend/augend, two's complement.
REQ-006 B  input  16  subtrahend/addend, two's complement.
REQ-007 sub  input  1  1 = A-B, 0 = A+B.
REQ-008 Sum  output  16  registered result, held until the next completion.
REQ-009 Ovfl  output  1  signed overflow of the completed operation.
REQ-010 Z  output  1  Sum == 0.
REQ-011 N  output  1  Sum[15].
REQ-012 busy  output  1  operation in progress; start ignored.
REQ-013 done  output  1  one-cycle pulse; Sum and flags are valid from this cycle on.

Function
REQ-014 SHALL contain a three-state FSM:
  - IDLE: start -> RUN.
  - RUN: nibble counter 0..3; after nibble 3 -> DONE.
  - DONE: start -> RUN; otherwise -> IDLE.
REQ-015 On an accepted start, SHALL latch:
  - A and sub.
  - Bin = sub ? ~B : B.
  - carry register = sub (the +1 of two's-complement negation).
  - nibble counter = 0.
REQ-016 Each RUN edge SHALL process the nibble selected by the counter:
  - add A[4i+3:4i] + Bin[4i+3:4i] + carry.
  - write the 4-bit result into the working register.
  - update carry from the nibble carry-out.
  - increment the counter.
REQ-017 Latency: start accepted at edge k; nibbles 0..3 processed at edges k+1..k+4; done high for the cycle following edge k+4.
REQ-018 busy SHALL be high from edge k to edge k+4, and low in the DONE cycle.
REQ-019 Working register and output register SHALL be separate. Sum, Ovfl, Z and N change only at the completing edge (k+4).
REQ-020 Ovfl SHALL be (A[15] == Bin[15]) AND (raw result[15] != A[15]), using the latched operands.
REQ-021 Arithmetic SHALL be modulo 2^16. Carry out of bit 15 SHALL be discarded and not exposed.
REQ-022 Z and N SHALL be computed from the final Sum value written (after saturation when it is enabled).
REQ-023 start while busy SHALL be ignored: no operand re-latch, and the result in progress is unaffected.
REQ-024 start in the DONE cycle SHALL be accepted, giving back-to-back operations with one done pulse per operation and a throughput of one result per 5 cycles.
REQ-025 A, B and sub SHALL be don't-care except at the accepting edge.

Reset
REQ-026 On rst_n low, all of the following SHALL clear immediately, regardless of clock:
  - FSM = IDLE.
  - Sum = 0x0000, Ovfl = 0, Z = 0, N = 0, busy = 0, done = 0.
  - counter, carry and working register = 0.
REQ-027 Reset mid-operation SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-028 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro ADDSUB_SAT_EN SHALL select saturation.
REQ-030 With ADDSUB_SAT_EN defined, if overflow occurs Sum SHALL be 0x7FFF when A[15]=0 and 0x8000 when A[15]=1. Ovfl is still reported as 1.
REQ-031 Without ADDSUB_SAT_EN, Sum SHALL be the wrapped modulo-2^16 result. All other behaviour and timing are identical.

Verification
REQ-032 A=0x1234, B=0x0FFF, sub=0, start -> done 4 cycles later; Sum=0x2233, Ovfl=0, Z=0, N=0; busy high for the preceding 4 cycles.
REQ-033 A=0x7FFF, B=0x0001, sub=0 -> Ovfl=1:
  - without SAT: Sum=0x8000, N=1.
  - with SAT: Sum=0x7FFF, N=0.
REQ-034 A=0x8000, B=0x0001, sub=1 -> Ovfl=1:
  - without SAT: Sum=0x7FFF.
  - with SAT: Sum=0x8000, N=1.
  Also: A=0x0005, B=0x0005, sub=1 -> Sum=0x0000, Z=1.
REQ-035 Start 0x0001+0x0001; pulse start again with A=0xFFFF two cycles later -> ignored, Sum=0x0002. Then start in the DONE cycle with 0x0003-0x0004 -> Sum=0xFFFF, N=1, done 5 cycles after the first done.
REQ-036 Start 0x1111+0x2222; assert rst_n low at the 2nd RUN cycle -> all outputs 0 immediately, no done. After release, 0x0001+0x0002 -> Sum=0x0003.

Source files
------------

// File: rtl/addsub_16bit_serial.sv
// addsub_16bit_serial: 16-bit two's-complement add/subtract, one nibble per clock over four RUN cycles.
// Define ADDSUB_SAT_EN to saturate Sum on signed overflow; by default Sum wraps modulo 2^16.
module addsub_16bit_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic [15:0] Sum,
  output logic        Ovfl,
  output logic        Z,
  output logic        N,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [15:0] a_q, bin_q, work_q, sum_q;
  logic [1:0]  cnt_q;
  logic        carry_q, ovfl_q, z_q, n_q, busy_q, done_q;
  logic [4:0]  nib_d;
  logic [15:0] work_d, res_d;
  logic        ovfl_d, accept;
  assign accept = start && state_q != RUN;
  always_comb begin
    nib_d = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} + {1'b0, bin_q[{cnt_q, 2'b00} +: 4]} + {4'b0, carry_q};
    work_d = work_q;
    work_d[{cnt_q, 2'b00} +: 4] = nib_d[3:0];
    ovfl_d = (a_q[15] == bin_q[15]) && (work_d[15] != a_q[15]);
`ifdef ADDSUB_SAT_EN
    res_d = ovfl_d ? (a_q[15] ? 16'h8000 : 16'h7FFF) : work_d;
`else
    res_d = work_d;
`endif
  end
  // work_d/res_d are only meaningful on the cnt_q==3 RUN edge, where work_d holds the full raw result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovfl_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        a_q     <= A;
        bin_q   <= sub ? ~B : B;
        carry_q <= sub;
        cnt_q   <= 2'd0;
        busy_q  <= 1'b1;
      end else if (state_q == RUN) begin
        work_q  <= work_d;
        carry_q <= nib_d[4];
        cnt_q   <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          sum_q   <= res_d;
          ovfl_q  <= ovfl_d;
          z_q     <= res_d == 16'h0000;
          n_q     <= res_d[15];
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign Sum  = sum_q;
  assign Ovfl = ovfl_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
